// File: rtl/reg_wb_queue.sv
// -----------------------------------------------------------------------------
// reg_wb_queue
//
// Write-side front end for the 8x16 register file. Write requests arrive over a
// valid/ready handshake, are buffered in an in-order FIFO, and are issued to the
// register file write port (WS/WE/IN) at most one per clock through a
// registered issue stage. Two forwarding lookups (RS1/RS2) return the newest
// pending value for a register so that readers see writes not yet committed.
//
// Register 0 is hardwired to zero: requests to it are accepted and dropped, and
// lookups of it never hit.
//
// Optional feature (compile-time macro WB_COALESCE_EN):
//   A nonzero request whose sel matches the youngest FIFO entry overwrites
//   that entry's data instead of enqueuing, provided the youngest entry is not
//   popping this cycle. In that case req_ready may assert even when the queue
//   is full, so req_ready depends combinationally on req_sel.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
//   AW     register select width
//   DW     data width
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   write request handshake
//   req_sel, req_data     destination register and write value
//   wb_stall              inhibits issue to the register file this cycle
//   WS, WE, IN            registered register-file write port
//   RS1, RS2              forwarding lookup addresses
//   FWD1_HIT/FWD1_DATA    newest pending value for RS1 (0 when no hit)
//   FWD2_HIT/FWD2_DATA    newest pending value for RS2 (0 when no hit)
//   count                 FIFO occupancy, excluding the issue register
//   empty                 no FIFO entries and no write being issued
// -----------------------------------------------------------------------------
module reg_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 3,
    parameter int DW    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [AW-1:0]              req_sel,
    input  logic [DW-1:0]              req_data,
    input  logic                       wb_stall,
    output logic [AW-1:0]              WS,
    output logic                       WE,
    output logic [DW-1:0]              IN,
    input  logic [AW-1:0]              RS1,
    input  logic [AW-1:0]              RS2,
    output logic                       FWD1_HIT,
    output logic [DW-1:0]              FWD1_DATA,
    output logic                       FWD2_HIT,
    output logic [DW-1:0]              FWD2_DATA,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] sel_q  [DEPTH];
    logic [AW-1:0] sel_d  [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          we_q,     we_d;
    logic [AW-1:0] ws_q,     ws_d;
    logic [DW-1:0] in_q,     in_d;

    logic full;
    logic pop;
    logic coal_hit;
    logic accept;
    logic push;

    assign full = (count_q == CW'(DEPTH));
    assign pop  = (count_q != '0) && !wb_stall;

`ifdef WB_COALESCE_EN
    logic [PW-1:0] young_idx;
    assign young_idx = wr_ptr_q - 1'b1;
    // The youngest entry can only absorb the request if it is not the one
    // leaving the queue this cycle.
    assign coal_hit  = (req_sel != '0) && (count_q != '0) &&
                       (sel_q[young_idx] == req_sel) &&
                       ((count_q > CW'(1)) || wb_stall);
`else
    assign coal_hit  = 1'b0;
`endif

    // Ready is a function of registered occupancy (plus req_sel when
    // coalescing), never of the pop decision.
    assign req_ready = !full || coal_hit;
    assign accept    = req_valid && req_ready;
    assign push      = accept && (req_sel != '0) && !coal_hit;

    always_comb begin
        sel_d    = sel_q;
        data_d   = data_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        we_d     = pop;
        ws_d     = ws_q;
        in_d     = in_q;

        if (push) begin
            sel_d[wr_ptr_q]  = req_sel;
            data_d[wr_ptr_q] = req_data;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
`ifdef WB_COALESCE_EN
        if (accept && coal_hit) begin
            data_d[young_idx] = req_data;
        end
`endif
        if (pop) begin
            ws_d     = sel_q[rd_ptr_q];
            in_d     = data_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            ws_q     <= '0;
            in_q     <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            ws_q     <= ws_d;
            in_q     <= in_d;
        end
    end

    // Entry storage needs no reset: validity is carried by the pointers/count.
    always_ff @(posedge clk) begin
        sel_q  <= sel_d;
        data_q <= data_d;
    end

    // Returns {hit, data}. Scans oldest to youngest so the youngest match wins;
    // the issue register is seeded first as the lowest-priority candidate.
    function automatic logic [DW:0] fwd_lookup(input logic [AW-1:0] rs);
        logic          hit;
        logic [DW-1:0] val;
        logic [PW-1:0] idx;
        hit = we_q && (ws_q == rs);
        val = hit ? in_q : '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if ((i < int'(count_q)) && (sel_q[idx] == rs)) begin
                hit = 1'b1;
                val = data_q[idx];
            end
        end
        if (rs == '0) begin
            hit = 1'b0;
            val = '0;
        end
        return {hit, val};
    endfunction

    assign {FWD1_HIT, FWD1_DATA} = fwd_lookup(RS1);
    assign {FWD2_HIT, FWD2_DATA} = fwd_lookup(RS2);

    assign WS    = ws_q;
    assign WE    = we_q;
    assign IN    = in_q;
    assign count = count_q;
    assign empty = (count_q == '0) && !we_q;

endmodule

// File: tb/tb_reg_wb_queue.sv
module tb_reg_wb_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_sel = '0;
    logic [15:0] req_data = '0;
    logic        wb_stall = 1'b0;
    logic [2:0]  WS;
    logic        WE;
    logic [15:0] IN;
    logic [2:0]  RS1 = '0;
    logic [2:0]  RS2 = '0;
    logic        FWD1_HIT, FWD2_HIT;
    logic [15:0] FWD1_DATA, FWD2_DATA;
    logic [2:0]  count;
    logic        empty;

    reg_wb_queue #(.DEPTH(DEPTH), .AW(3), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_data(req_data),
        .wb_stall(wb_stall),
        .WS(WS), .WE(WE), .IN(IN),
        .RS1(RS1), .RS2(RS2),
        .FWD1_HIT(FWD1_HIT), .FWD1_DATA(FWD1_DATA),
        .FWD2_HIT(FWD2_HIT), .FWD2_DATA(FWD2_DATA),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    // Reference model: pending writes as a queue (front = oldest) plus the
    // register-file write port as last issued.
    typedef struct packed {
        logic [2:0]  sel;
        logic [15:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_we = 1'b0;
    logic [2:0]  m_ws = '0;
    logic [15:0] m_in = '0;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] m_fwd(input logic [2:0] rs);
        if (rs == 3'd0) return '0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].sel == rs) return {1'b1, mq[i].data};
        if (m_we && m_ws == rs) return {1'b1, m_in};
        return '0;
    endfunction

    function automatic logic m_coal(input logic [2:0] s, input logic st);
`ifdef WB_COALESCE_EN
        return (s != 3'd0) && (mq.size() > 0) && (mq[mq.size()-1].sel == s) &&
               ((mq.size() > 1) || st);
`else
        return 1'b0;
`endif
    endfunction

    // One clock: drive at the falling edge, check pre-edge state, then apply
    // the rising edge to the model.
    task automatic step(input logic v, input logic [2:0] s, input logic [15:0] d,
                        input logic st, input logic [2:0] r1, input logic [2:0] r2);
        logic        rdy, acc, pop, coal;
        logic [16:0] f1, f2;
        ent_t        head;
        @(negedge clk);
        req_valid = v; req_sel = s; req_data = d; wb_stall = st; RS1 = r1; RS2 = r2;
        #1;
        coal = m_coal(s, st);
        rdy  = (mq.size() != DEPTH) || coal;
        f1   = m_fwd(r1);
        f2   = m_fwd(r2);
        chk("req_ready", 32'(req_ready), 32'(rdy));
        chk("count", 32'(count), 32'(mq.size()));
        chk("empty", 32'(empty), 32'((mq.size() == 0) && !m_we));
        chk("WE", 32'(WE), 32'(m_we));
        chk("WS", 32'(WS), 32'(m_ws));
        chk("IN", 32'(IN), 32'(m_in));
        chk("FWD1_HIT", 32'(FWD1_HIT), 32'(f1[16]));
        chk("FWD1_DATA", 32'(FWD1_DATA), 32'(f1[15:0]));
        chk("FWD2_HIT", 32'(FWD2_HIT), 32'(f2[16]));
        chk("FWD2_DATA", 32'(FWD2_DATA), 32'(f2[15:0]));
        acc = v && rdy;
        pop = (mq.size() > 0) && !st;
        @(posedge clk);
        if (pop) begin
            head = mq.pop_front();
            m_we = 1'b1; m_ws = head.sel; m_in = head.data;
        end else begin
            m_we = 1'b0;
        end
        if (acc && s != 3'd0) begin
            if (coal) mq[mq.size()-1].data = d;
            else      mq.push_back('{sel: s, data: d});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 3'd0, 16'h0, 1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    endtask

    logic [2:0] rsel;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_WE", 32'(WE), 32'd0);
        chk("rst_WS", 32'(WS), 32'd0);
        chk("rst_IN", 32'(IN), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        rst_n = 1'b1;

        // Single write: WE one cycle after acceptance, empty again after that
        step(1'b1, 3'd1, 16'h1234, 1'b0, 3'd1, 3'd0);
        idle(3);

        // Fill under stall, then drain in order
        step(1'b1, 3'd1, 16'hBEEF, 1'b1, 3'd1, 3'd2);
        step(1'b1, 3'd2, 16'hDEAD, 1'b1, 3'd1, 3'd2);
        step(1'b1, 3'd3, 16'hFFFF, 1'b1, 3'd3, 3'd4);
        step(1'b1, 3'd4, 16'hABCD, 1'b1, 3'd4, 3'd1);
        step(1'b1, 3'd5, 16'h7777, 1'b0, 3'd4, 3'd5); // full: rejected despite pop
        idle(6);

        // Forwarding of the newest value for a repeated register
        step(1'b1, 3'd3, 16'hBADE, 1'b1, 3'd3, 3'd5);
        step(1'b1, 3'd3, 16'h0000, 1'b1, 3'd3, 3'd5);
        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd5);
        idle(4);

        // r0 writes are accepted and dropped
        step(1'b1, 3'd0, 16'hBADE, 1'b0, 3'd0, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0);

        // Asynchronous reset mid-drain
        step(1'b1, 3'd6, 16'h6666, 1'b1, 3'd6, 3'd7);
        step(1'b1, 3'd7, 16'h7777, 1'b0, 3'd6, 3'd7);
        @(negedge clk);
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_WE", 32'(WE), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        mq.delete(); m_we = 1'b0; m_ws = '0; m_in = '0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

`ifdef WB_COALESCE_EN
        // Coalescing into the youngest entry of a full queue
        step(1'b1, 3'd1, 16'h1111, 1'b1, 3'd4, 3'd1);
        step(1'b1, 3'd2, 16'h2222, 1'b1, 3'd4, 3'd1);
        step(1'b1, 3'd3, 16'h3333, 1'b1, 3'd4, 3'd1);
        step(1'b1, 3'd4, 16'h4444, 1'b1, 3'd4, 3'd1);
        step(1'b1, 3'd4, 16'h5555, 1'b1, 3'd4, 3'd1);
        idle(6);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rsel = 3'($urandom_range(0, 7));
            step(1'($urandom_range(0, 3) != 0), rsel, 16'($urandom),
                 1'($urandom_range(0, 2) == 0),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_wb_queue.md
Name: reg_wb_queue

Overview:
- Write-side front end for the 8x16 register file. Sits between the execute/writeback stage and the register file write port (WS/WE/IN).
- Accepts write requests over a valid/ready handshake and buffers them in an in-order FIFO. Issues at most one write per clock to the register file.
- Provides forwarding lookups so readers on RS1/RS2 see the newest pending value before it is committed.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 3, register select width (8 registers).
- DW, 16, data width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  write request present.
- req_ready  out  1  queue can accept the request this cycle.
- req_sel  in  AW  destination register.
- req_data  in  DW  write value.
- wb_stall  in  1  inhibits issue to the register file this cycle.
- WS  out  AW  register file write select (registered).
- WE  out  1  register file write enable (registered).
- IN  out  DW  register file write data (registered).
- RS1  in  AW  lookup address 1; tie to the register file RS1.
- RS2  in  AW  lookup address 2; tie to the register file RS2.
- FWD1_HIT  out  1  a pending write matches RS1 (combinational).
- FWD1_DATA  out  DW  newest pending value for RS1; 0 when no hit.
- FWD2_HIT  out  1  a pending write matches RS2 (combinational).
- FWD2_DATA  out  DW  newest pending value for RS2; 0 when no hit.
- count  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the issue register.
- empty  out  1  count==0 and WE==0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO pointers and count go to 0.
  - WE=0, WS=0, IN=0.
  - All pending entries are discarded, including a reset mid-drain; no partial write is issued.
- Handshake:
  - Transfer occurs when req_valid && req_ready at a rising edge.
  - req_ready = (count != DEPTH), unless widened by the optional feature below.
  - req_valid is ignored while rst_n is low.
- r0 is hardwired zero:
  - A transfer with req_sel==0 is accepted (ready obeys the rules above) and discarded.
  - It neither enqueues nor changes count.
- Issue (each rising edge):
  - If count>0 and !wb_stall: pop the head; WE<=1, WS<=head.sel, IN<=head.data.
  - Otherwise WE<=0; WS and IN hold their values.
- Latency: enqueue at edge N → WE=1 after edge N+1 (empty queue, no stall) → register file captures at edge N+2.
- Pops are strictly in enqueue order. Throughput is one write per cycle.
- Simultaneous enqueue and pop: count unchanged. A new entry may enqueue in the same cycle the head pops, provided count<DEPTH before the edge.
- Full queue: req_ready=0 even if a pop occurs that cycle; there is no combinational path from pop to ready.
- Pointers wrap modulo DEPTH.
- Forwarding for each of RS1/RS2:
  - Candidates are all valid FIFO entries plus the issue register while WE=1.
  - Priority, highest first: youngest FIFO entry → oldest FIFO entry → issue register.
  - Lookup with RS==0 always gives HIT=0, DATA=0.
  - Lookups see state before the current edge; a same-cycle incoming request is not forwarded.
- count and empty are derived from registered state only.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined:
  - A request with req_sel!=0 whose req_sel equals the youngest FIFO entry's sel overwrites that entry's data in place instead of enqueuing. count is unchanged.
  - The youngest entry must not be popping this cycle: count>1, or wb_stall=1.
  - When the queue is full, req_ready additionally asserts for such a matching request, so req_ready depends combinationally on req_sel.
- Undefined: every nonzero request enqueues. req_ready = (count!=DEPTH).

Test Plan:
1. Reset, then enqueue sel=1 data=16'h1234 with no stall → WE=1, WS=1, IN=16'h1234 one cycle after acceptance; empty=1 one cycle later.
2. wb_stall=1, enqueue sel 1..4 with data 16'hBEEF, 16'hDEAD, 16'hFFFF, 16'hABCD → count=4, req_ready=0. Release stall → four consecutive WE=1 cycles in order 1,2,3,4.
3. wb_stall=1, enqueue sel=3 16'hBADE then sel=3 16'h0000; RS1=3 → FWD1_HIT=1, FWD1_DATA=16'h0000. RS2=5 → FWD2_HIT=0, FWD2_DATA=0.
4. Enqueue sel=0 data=16'hBADE → accepted, count stays 0, WE stays 0. RS1=0 → FWD1_HIT=0.
5. With 2 entries queued, drop rst_n between clock edges → WE=0 and count=0 immediately. After release, no write issues.
6. WB_COALESCE_EN defined, wb_stall=1, queue full with youngest sel=4. Request sel=4 16'h5555 → req_ready=1, count stays 4. Release stall → last write is sel=4 16'h5555.
